// File: rtl/btb_assoc.sv
// N-way set-associative BTB with saturating direction counters, tree-PLRU replacement and
// a one-deep pending-write register that is bypassed to lookups. Optional flush: BTB_FLUSH_EN.
module btb_assoc #(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    parameter int CTR_W = 2,
    parameter logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        valid,
    output logic        predicted_taken,
    output logic [31:0] target_pc,
    input  logic        update,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        mispredicted
`ifdef BTB_FLUSH_EN
    ,
    input  logic        flush
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [SETS-1:0][WAYS-1:0] vld_q;
    logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
    logic [31:0]               tgt_q  [SETS][WAYS];
    logic [CTR_W-1:0]          ctr_q  [SETS][WAYS];
    logic [WAYS-2:0]           plru_q [SETS];
    logic [WAYS-2:0]           plru_d [SETS];

    logic             pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0] pend_idx_q;
    logic [WAY_W-1:0] pend_way_q, pend_way_d;
    logic [TAG_W-1:0] pend_tag_q;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic [CTR_W-1:0] pend_ctr_q, pend_ctr_d;

    logic flush_w;
`ifdef BTB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc[1:0], update_pc[1:0]};

    // Tree node n sits at depth d; bit=1 means the victim lies in the right subtree.
    function automatic int node_depth(int n);
        return $clog2(n + 2) - 1;
    endfunction

    function automatic logic on_path(int n, int w);
        return (w >> (WAY_W - node_depth(n))) == (n + 1 - (1 << node_depth(n)));
    endfunction

    function automatic logic goes_right(int n, int w);
        return ((w >> (WAY_W - 1 - node_depth(n))) & 1) == 1;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(logic [WAYS-2:0] bits, logic [WAY_W-1:0] way);
        logic [WAYS-2:0] b;
        b = bits;
        for (int n = 0; n < WAYS - 1; n++) begin
            if (on_path(n, int'(way))) b[n] = !goes_right(n, int'(way));
        end
        return b;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(logic [WAYS-2:0] bits);
        logic [WAY_W-1:0] v;
        logic             ok;
        v = '0;
        for (int w = 0; w < WAYS; w++) begin
            ok = 1'b1;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (on_path(n, w) && (bits[n] != goes_right(n, w))) ok = 1'b0;
            end
            if (ok) v = WAY_W'(w);
        end
        return v;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_next(logic [CTR_W-1:0] c, logic taken, logic mis);
        if (taken) return (&c) ? c : c + 1'b1;
        if (mis && (c >= CTR_INIT)) return CTR_INIT - 1'b1;
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic [WAYS-1:0]  l_hit;
    logic [WAY_W-1:0] l_way;
    logic [31:0]      l_tgt;
    logic [CTR_W-1:0] l_ctr;

    assign l_idx = pc[IDX_W+1:2];
    assign l_tag = pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];

    // Lookup: a pending write is visible only to a lookup with the same index and tag.
    always_comb begin
        l_hit = '0;
        l_way = '0;
        l_tgt = '0;
        l_ctr = '0;
        for (int w = 0; w < WAYS; w++) begin
            logic byp;
            byp = pend_vld_q && (pend_idx_q == l_idx) && (pend_way_q == WAY_W'(w)) && (pend_tag_q == l_tag);
            if (byp || (vld_q[l_idx][w] && (tag_q[l_idx][w] == l_tag))) begin
                l_hit[w] = 1'b1;
                l_way    = WAY_W'(w);
                l_tgt    = byp ? pend_tgt_q : tgt_q[l_idx][w];
                l_ctr    = byp ? pend_ctr_q : ctr_q[l_idx][w];
            end
        end
        valid           = |l_hit;
        predicted_taken = valid & l_ctr[CTR_W-1];
        target_pc       = valid ? l_tgt : 32'h0;
    end

    logic             u_hit, u_inv;
    logic [WAY_W-1:0] u_way, u_inv_way;
    logic [31:0]      u_tgt;
    logic [CTR_W-1:0] u_ctr;
    logic [WAYS-2:0]  u_plru;

    // Update sees the array with the pending entry overlaid, so back-to-back updates chain.
    always_comb begin
        u_hit     = 1'b0;
        u_way     = '0;
        u_tgt     = '0;
        u_ctr     = '0;
        u_inv     = 1'b0;
        u_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            logic             ov;
            logic             ev;
            logic [TAG_W-1:0] et;
            ov = pend_vld_q && (pend_idx_q == u_idx) && (pend_way_q == WAY_W'(w));
            ev = ov || vld_q[u_idx][w];
            et = ov ? pend_tag_q : tag_q[u_idx][w];
            if (ev && (et == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
                u_tgt = ov ? pend_tgt_q : tgt_q[u_idx][w];
                u_ctr = ov ? pend_ctr_q : ctr_q[u_idx][w];
            end
            if (!ev) begin
                u_inv     = 1'b1;
                u_inv_way = WAY_W'(w);
            end
        end
        u_plru = plru_q[u_idx];
        if (pend_vld_q && (pend_idx_q == u_idx)) u_plru = plru_touch(u_plru, pend_way_q);

        pend_vld_d = 1'b0;
        pend_way_d = u_way;
        pend_tgt_d = update_target;
        pend_ctr_d = CTR_INIT;
        if (update && !flush_w) begin
            if (u_hit) begin
                pend_vld_d = 1'b1;
                pend_tgt_d = update_taken ? update_target : u_tgt;
                pend_ctr_d = ctr_next(u_ctr, update_taken, mispredicted);
            end else if (update_taken) begin
                pend_vld_d = 1'b1;
                pend_way_d = u_inv ? u_inv_way : plru_victim(u_plru);
            end
        end
    end

    // Lookup touch first, then the write touch, so a same-set write wins.
    always_comb begin
        plru_d = plru_q;
        if (|l_hit) plru_d[l_idx] = plru_touch(plru_d[l_idx], l_way);
        if (pend_vld_q) plru_d[pend_idx_q] = plru_touch(plru_d[pend_idx_q], pend_way_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            vld_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= '0;
            end
        end else if (flush_w) begin
            pend_vld_q <= 1'b0;
            vld_q      <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            plru_q     <= plru_d;
            if (pend_vld_q) begin
                vld_q[pend_idx_q][pend_way_q] <= 1'b1;
                ctr_q[pend_idx_q][pend_way_q] <= pend_ctr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend_vld_d) begin
            pend_idx_q <= u_idx;
            pend_way_q <= pend_way_d;
            pend_tag_q <= u_tag;
            pend_tgt_q <= pend_tgt_d;
            pend_ctr_q <= pend_ctr_d;
        end
        if (pend_vld_q) begin
            tag_q[pend_idx_q][pend_way_q] <= pend_tag_q;
            tgt_q[pend_idx_q][pend_way_q] <= pend_tgt_q;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(l_hit));

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer for the RV32IM fetch stage.
- Successor to the fixed 8-set/2-way BTB.
- Adds:
  - configurable sets and ways
  - per-entry saturating direction counters
  - tree-PLRU replacement
  - invalid-way-first allocation
  - write-to-read bypass of the registered update
- Fetch does a combinational lookup on `pc`; execute reports resolved branches on the update port.

Parameters:
- SETS, 8, number of sets; power of 2, ≥2; IDX_W = log2(SETS).
- WAYS, 2, ways per set; power of 2, 2..8; PLRU bits per set = WAYS-1.
- CTR_W, 2, direction counter width; taken when counter MSB is 1.
- CTR_INIT, 2'b10, counter value loaded on allocation (weakly taken).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  input  32  fetch PC; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
- valid  output  1  lookup hit.
- predicted_taken  output  1  valid & counter MSB.
- target_pc  output  32  target of hit entry; 0 on miss.
- update  input  1  resolved control-transfer report this cycle.
- update_pc  input  32  PC of the resolved instruction.
- update_target  input  32  resolved target address.
- update_taken  input  1  actual branch direction.
- mispredicted  input  1  prediction was wrong; sets re-train priority.

Behaviour:
- Reset (rst_n=0, async):
  - all valid bits, counters and PLRU bits = 0
  - pending-write register cleared
  - outputs valid=0, predicted_taken=0, target_pc=0 in the same cycle
- Lookup (combinational, zero latency):
  - compare tag against all ways of the indexed set
  - at most one way hits; hit way drives target_pc and counter
  - multiple hits are impossible by construction; assert in simulation
- Update, cycle N (combinational on update_* against array contents):
  - Hit way: counter += 1 if update_taken (saturate at all-ones), else -= 1 (saturate at 0). Target overwritten with update_target if update_taken.
  - Miss & update_taken: allocate. Victim = lowest-numbered invalid way, else the PLRU victim. Write tag, target, valid=1, counter=CTR_INIT.
  - Miss & !update_taken: no write.
  - mispredicted=1 on a hit with update_taken=0 and counter ≥ CTR_INIT: counter set to CTR_INIT-1 (forced not-taken) instead of a single decrement.
- Write, cycle N+1: the computed entry is registered and written to the array at the end of cycle N+1. It is architecturally visible from cycle N+2.
- Bypass: during cycle N+1, a lookup whose index and tag match the pending write returns the pending entry, not stale array data. This covers the allocation case.
- PLRU (per set, tree):
  - touched on every lookup hit (cycle of lookup)
  - touched on every update write (cycle N+1, at array write)
  - same-set collision in one cycle: the update touch is applied last and wins
  - lookup touch on a different set is applied independently
- Back-to-back updates to the same entry on consecutive cycles: the second update's cycle-N computation uses the pending (bypassed) entry, not the array. No lost counter increments.
- Simultaneous lookup and pending write to the same set but a different tag: lookup sees the array; no corruption.
- Reset asserted mid-update: the pending write is discarded.

Optional Feature:
- Macro: BTB_FLUSH_EN.
- Defined:
  - adds input flush (1 bit)
  - flush=1 clears all valid bits and PLRU bits at the next edge
  - cancels any pending write; update in the same cycle is ignored
  - lookups return miss from the following cycle
- Undefined: no flush port; entries are invalidated only by rst_n.

Test Plan:
- Reset then lookup pc=0x0000_0100 -> valid=0, predicted_taken=0, target_pc=0.
- Update pc=0x100, target=0x200, taken=1 at cycle N -> lookup 0x100 at N+1 via bypass and at N+2 from the array returns valid=1, taken=1, target 0x200.
- Same entry, three consecutive not-taken updates:
  - counter 10→01→00→00 (saturates)
  - predicted_taken=0
  - counter reads 0 after a fourth update
- Fill one set (SETS=8, WAYS=2): pcs 0x100 and 0x120 both taken, then lookup 0x100, then allocate 0x140 -> 0x120 evicted (PLRU), 0x100 and 0x140 hit.
- mispredicted=1, taken=0 on an entry with counter 11 -> counter becomes 01; next lookup predicted_taken=0, valid=1.
- With BTB_FLUSH_EN: allocate 0x100, pulse flush together with an update to 0x140 -> both miss from the next cycle.
